// File: rtl/reaction_time_bcd.sv
// Binary-to-BCD converter for the reaction timer: sequential double-dabble, saturating at 10^DIGITS-1.
// Optional 7-segment output via REACTION_TIME_SEG7_EN.
module reaction_time_bcd #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
`ifdef REACTION_TIME_SEG7_EN
   ,
   output logic [7*DIGITS-1:0]   hex
`endif
);

   localparam int BW    = 4 * DIGITS;
   localparam int CW    = $clog2(WIDTH + 1);
   localparam int LIMIT = (10 ** DIGITS) - 1;
   localparam logic [WIDTH-1:0] SAT = WIDTH'(LIMIT);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t              r_state, w_state_next;
   logic [WIDTH-1:0]    r_bin, w_bin_next;
   logic [BW-1:0]       r_scratch, w_scratch_next;
   logic [CW-1:0]       r_cnt, w_cnt_next;
   logic                r_ovf_pend, w_ovf_pend_next;
   logic                r_busy, w_busy_next;
   logic                r_done, w_done_next;
   logic [BW-1:0]       r_bcd, w_bcd_next;
   logic                r_ovf, w_ovf_next;
   logic [BW-1:0]       w_adj;
   logic                w_over;

   assign w_over = (32'(value) > 32'(LIMIT));

   // Add-3 correction applied to every digit in parallel before each shift.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5) ?
                                   (r_scratch[gi*4 +: 4] + 4'd3) : r_scratch[gi*4 +: 4];
      end
   endgenerate

`ifdef REACTION_TIME_SEG7_EN
   logic [7*DIGITS-1:0] r_hex, w_hex_next, w_seg;

   // Active-low segments, bit order g..a.
   function automatic logic [6:0] f_seg7(input logic [3:0] d);
      case (d)
         4'd0:    f_seg7 = 7'b1000000;
         4'd1:    f_seg7 = 7'b1111001;
         4'd2:    f_seg7 = 7'b0100100;
         4'd3:    f_seg7 = 7'b0110000;
         4'd4:    f_seg7 = 7'b0011001;
         4'd5:    f_seg7 = 7'b0010010;
         4'd6:    f_seg7 = 7'b0000010;
         4'd7:    f_seg7 = 7'b1111000;
         4'd8:    f_seg7 = 7'b0000000;
         4'd9:    f_seg7 = 7'b0010000;
         default: f_seg7 = 7'b1111111;
      endcase
   endfunction

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
         assign w_seg[gi*7 +: 7] = r_ovf_pend ? 7'b0111111 : f_seg7(r_scratch[gi*4 +: 4]);
      end
   endgenerate

   always_comb begin
      w_hex_next = r_hex;
      if (r_state == FINISH) w_hex_next = w_seg;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_hex <= '1;
      else          r_hex <= w_hex_next;
   end

   assign hex = r_hex;
`endif

   always_comb begin
      w_state_next    = r_state;
      w_bin_next      = r_bin;
      w_scratch_next  = r_scratch;
      w_cnt_next      = r_cnt;
      w_ovf_pend_next = r_ovf_pend;
      w_busy_next     = r_busy;
      w_done_next     = 1'b0;
      w_bcd_next      = r_bcd;
      w_ovf_next      = r_ovf;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_bin_next      = w_over ? SAT : value;
               w_ovf_pend_next = w_over;
               w_scratch_next  = '0;
               w_cnt_next      = '0;
               w_busy_next     = 1'b1;
               w_state_next    = SHIFT;
            end
         end
         SHIFT: begin
            {w_scratch_next, w_bin_next} = {w_adj, r_bin} << 1;
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) w_state_next = FINISH;
         end
         FINISH: begin
            w_bcd_next   = r_scratch;
            w_ovf_next   = r_ovf_pend;
            w_done_next  = 1'b1;
            w_busy_next  = 1'b0;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_bin      <= '0;
         r_scratch  <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_bin      <= w_bin_next;
         r_scratch  <= w_scratch_next;
         r_cnt      <= w_cnt_next;
         r_ovf_pend <= w_ovf_pend_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_bcd      <= w_bcd_next;
         r_ovf      <= w_ovf_next;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign bcd  = r_bcd;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_reaction_time_bcd.sv
// Scoreboard bench for reaction_time_bcd: decimal reference model, randomized values,
// handshake/latency checks, ignored start while busy, and mid-conversion reset.
module tb_reaction_time_bcd;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic [13:0] value   = '0;
   logic        busy, done, ovf;
   logic [15:0] bcd;
`ifdef REACTION_TIME_SEG7_EN
   logic [27:0] hex;
`endif

   reaction_time_bcd #(.WIDTH(14), .DIGITS(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .value   (value),
      .busy    (busy),
      .done    (done),
      .bcd     (bcd),
      .ovf     (ovf)
`ifdef REACTION_TIME_SEG7_EN
      ,
      .hex     (hex)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      logic [27:0] hex;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_conv   = 0;
   logic        prev_done = 1'b0;
   logic [6:0]  seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: saturate, then peel decimal digits with / and %.
   function automatic exp_t model(input int v);
      exp_t e;
      int   m;
      int   d;
      m     = (v > 9999) ? 9999 : v;
      e.bcd = '0;
      e.hex = '0;
      e.ovf = (v > 9999);
      for (int i = 0; i < 4; i++) begin
         d = m % 10;
         m = m / 10;
         e.bcd[i*4 +: 4] = 4'(d);
         e.hex[i*7 +: 7] = e.ovf ? 7'b0111111 : seg_tab[d];
      end
      return e;
   endfunction

   // Monitor: pops one expectation per done pulse.
   always @(negedge clock) begin
      exp_t e;
      int   bad;
      if (!reset_n) begin
         prev_done = 1'b0;
      end else begin
         if (done) begin
            chk("done_single_cycle", int'(prev_done), 0);
            chk("pending_expectation", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e   = exp_q.pop_front();
               bad = 0;
               for (int i = 0; i < 4; i++) if (bcd[i*4 +: 4] > 4'd9) bad++;
               chk("digit_range", bad, 0);
               chk("bcd", int'(bcd), int'(e.bcd));
               chk("ovf", int'(ovf), int'(e.ovf));
`ifdef REACTION_TIME_SEG7_EN
               chk("hex", int'(hex), int'(e.hex));
`endif
               n_conv++;
               $display("conv %0d: bcd=%h ovf=%0b (expected bcd=%h ovf=%0b)",
                        n_conv, bcd, ovf, e.bcd, e.ovf);
            end
         end
         prev_done = done;
      end
   end

   // Called with the bench positioned #1 after a rising edge; returns in the done cycle.
   task automatic conv(input int v, input int inj);
      int t     = 0;
      int lat   = 0;
      int nbusy = 0;
      while (busy && t < 100) begin
         @(posedge clock); #1; t++;
      end
      chk("idle_before_start", int'(busy), 0);
      start = 1'b1;
      value = 14'(v);
      @(posedge clock); #1;
      start = 1'b0;
      value = 14'($urandom);
      exp_q.push_back(model(v));
      chk("busy_rise", int'(busy), 1);
      while (!done && lat < 100) begin
         if (busy) nbusy++;
         if (lat == inj) begin
            start = 1'b1;
            value = 14'd42;
         end else if (lat == inj + 1) begin
            start = 1'b0;
         end
         @(posedge clock); #1;
         lat++;
      end
      start = 1'b0;
      chk("latency", lat, 15);
      chk("busy_cycles", nbusy, 15);
      chk("busy_low_at_done", int'(busy), 0);
   endtask

   initial begin
      int v;
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_bcd", int'(bcd), 0);
      chk("rst_ovf", int'(ovf), 0);
`ifdef REACTION_TIME_SEG7_EN
      chk("rst_hex", int'(hex), 32'h0FFFFFFF);
`endif
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock); #1;

      conv(0, -1);
      conv(1234, -1);
      conv(9999, -1);
      conv(777, 4);       // start pulse at k+5 with value 42 must be ignored
      conv(16383, -1);

      // Mid-conversion reset: no expectation is queued for 5678.
      while (busy) begin @(posedge clock); #1; end
      start = 1'b1;
      value = 14'd5678;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (7) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_bcd", int'(bcd), 0);
      chk("async_rst_ovf", int'(ovf), 0);
      @(negedge clock); reset_n = 1'b1;
      @(posedge clock); #1;
      conv(7, -1);

      for (int n = 0; n < 1200; n++) begin
         case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 16383));
            1:       v = int'($urandom_range(9990, 10010));
            2:       v = int'($urandom_range(0, 99));
            default: v = int'($urandom_range(0, 9999));
         endcase
         conv(v, -1);
      end

      @(negedge clock); #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
